// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex seven-segment scan driver with load handshake, frame-boundary commit,
// anti-ghost guard cycles and per-digit blanking. Optional macro: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 4,
  parameter int GUARD    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PENDING = 1'b1;

  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [0:0]          state, state_n;
  logic [4*DIGITS-1:0] active, active_n;
  logic [4*DIGITS-1:0] pending;
  logic [DIGITS-1:0]   dark, an_n;
  logic [6:0]          seg_n;
  logic                wrap, frame_edge, accept;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0:    hex_to_seg = 7'h40;
      4'h1:    hex_to_seg = 7'h79;
      4'h2:    hex_to_seg = 7'h24;
      4'h3:    hex_to_seg = 7'h30;
      4'h4:    hex_to_seg = 7'h19;
      4'h5:    hex_to_seg = 7'h12;
      4'h6:    hex_to_seg = 7'h02;
      4'h7:    hex_to_seg = 7'h78;
      4'h8:    hex_to_seg = 7'h00;
      4'h9:    hex_to_seg = 7'h10;
      4'hA:    hex_to_seg = 7'h08;
      4'hB:    hex_to_seg = 7'h03;
      4'hC:    hex_to_seg = 7'h46;
      4'hD:    hex_to_seg = 7'h21;
      4'hE:    hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  function automatic logic [3:0] nibble_at(input logic [4*DIGITS-1:0] v, input logic [IDX_W-1:0] sel);
    nibble_at = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == sel) nibble_at = v[4*i +: 4];
    end
  endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Digit i is dark when nibbles i..MSD are all zero; digit 0 always stays lit.
  function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [4*DIGITS-1:0] v);
    logic seen;
    lead_zero_mask = '0;
    seen = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      seen = seen | (|v[4*i +: 4]);
      lead_zero_mask[i] = ~seen;
    end
  endfunction
`endif

  assign load_ready  = (state == S_IDLE);
  assign accept      = load_valid && load_ready;
  assign frame_start = ~rst & (cnt == '0) & (idx == '0);

  always_comb begin
    wrap       = (cnt == CNT_W'(PRESCALE - 1));
    frame_edge = wrap && (idx == IDX_W'(DIGITS - 1));
    cnt_n      = wrap ? '0 : cnt + CNT_W'(1);
    idx_n      = idx;
    if (wrap) idx_n = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);

    state_n  = state;
    active_n = active;
    case (state)
      S_IDLE:    if (accept) state_n = S_PENDING;
      default: begin
        if (frame_edge) begin
          active_n = pending;
          state_n  = S_IDLE;
        end
      end
    endcase

    // Outputs are registered, so they are computed from the values the counters take next.
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    dark = blank_mask | lead_zero_mask(active_n);
`else
    dark = blank_mask;
`endif
    an_n = '1;
    if (int'(cnt_n) >= GUARD && !dark[idx_n]) an_n[idx_n] = 1'b0;
    seg_n = hex_to_seg(nibble_at(active_n, idx_n));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      state  <= S_IDLE;
      active <= '0;
      seg    <= 7'h7F;
      an     <= '1;
    end else begin
      cnt    <= cnt_n;
      idx    <= idx_n;
      state  <= state_n;
      active <= active_n;
      seg    <= seg_n;
      an     <= an_n;
    end
  end

  // Pending data is only observed once the FSM is PENDING, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) pending <= load_data;
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: table-driven display frames through a scoreboard queue,
// plus hand sequences for commit timing, busy loads, frame-edge accept and mid-frame reset.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load_valid;
  logic [15:0] load_data;
  logic [3:0]  blank_mask;
  logic        load_ready;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  logic        lv2 = 1'b0;
  logic [15:0] ld2 = 16'h0;
  logic [3:0]  bm2 = 4'h0;
  logic        ready2;
  logic [6:0]  seg2;
  logic [3:0]  an2;
  logic        fs2;

  seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .GUARD(1)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .blank_mask(blank_mask), .seg(seg), .an(an),
    .frame_start(frame_start)
  );

  seg7_scan_driver #(.DIGITS(4), .PRESCALE(2), .GUARD(0)) dut2 (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_ready(ready2),
    .load_data(ld2), .blank_mask(bm2), .seg(seg2), .an(an2),
    .frame_start(fs2)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [3:0] LIT_00A0 = 4'b0011;
  localparam logic [3:0] LIT_0000 = 4'b0001;
  localparam logic [3:0] LIT_0F00 = 4'b0111;
  localparam bit         LZ       = 1'b1;
`else
  localparam logic [3:0] LIT_00A0 = 4'b1111;
  localparam logic [3:0] LIT_0000 = 4'b1111;
  localparam logic [3:0] LIT_0F00 = 4'b1111;
  localparam bit         LZ       = 1'b0;
`endif

  typedef struct {
    logic [15:0] value;
    logic [3:0]  mask;
    logic [6:0]  s0, s1, s2, s3;
    logic [3:0]  lit;
  } vec_t;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fs;
  } exp_t;

  localparam int NV = 8;
  vec_t vecs[NV];
  vec_t v5555, v3c3c, vzero;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_fs(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (frame_start) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) timeout("frame_start_wait");
  endtask

  task automatic wait_commit(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (frame_start && load_ready) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) timeout("commit_wait");
  endtask

  task automatic load_value(input logic [15:0] val);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (load_ready) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) begin timeout("ready_wait"); return; end
    load_valid = 1'b1;
    load_data  = val;
    tick();
    load_valid = 1'b0;
    chk("ready_low_after_accept", 32'(load_ready), 32'h0);
  endtask

  task automatic check_frame(input vec_t v, input string tag);
    bit         ok;
    exp_t       e;
    logic [6:0] s;
    logic [3:0] a;
    int         d, k;
    wait_commit(100, ok);
    if (!ok) return;
    for (int c = 0; c < 16; c++) begin
      d = c / 4;
      k = c % 4;
      case (d)
        0:       s = v.s0;
        1:       s = v.s1;
        2:       s = v.s2;
        default: s = v.s3;
      endcase
      a = 4'hF;
      if (k >= 1 && v.lit[d]) a = ~(4'b0001 << d);
      sb.push_back('{seg: s, an: a, fs: (c == 0)});
    end
    for (int c = 0; c < 16; c++) begin
      e = sb.pop_front();
      chk({tag, "_seg"}, 32'(seg), 32'(e.seg));
      chk({tag, "_an"}, 32'(an), 32'(e.an));
      chk({tag, "_fs"}, 32'(frame_start), 32'(e.fs));
      tick();
    end
    chk({tag, "_frame_len"}, 32'(frame_start), 32'h1);
  endtask

  task automatic check_dut2();
    bit         ok;
    exp_t       e;
    logic [3:0] a;
    int         d;
    ok = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      if (fs2) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) begin timeout("g0_frame_start_wait"); return; end
    for (int c = 0; c < 16; c++) begin
      d = (c / 2) % 4;
      a = 4'hF;
      if (!LZ || d == 0) a = ~(4'b0001 << d);
      sb.push_back('{seg: 7'h40, an: a, fs: (c % 8 == 0)});
    end
    for (int c = 0; c < 16; c++) begin
      e = sb.pop_front();
      chk("g0_seg", 32'(seg2), 32'(e.seg));
      chk("g0_an", 32'(an2), 32'(e.an));
      chk("g0_fs", 32'(fs2), 32'(e.fs));
      tick();
    end
  endtask

  initial begin
    bit         ok;
    logic [6:0] prev;

    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0;
    blank_mask = 4'h0;

    vecs[0] = '{16'h1234, 4'h0,    7'h19, 7'h30, 7'h24, 7'h79, 4'hF};
    vecs[1] = '{16'hABCD, 4'h0,    7'h21, 7'h46, 7'h03, 7'h08, 4'hF};
    vecs[2] = '{16'h8888, 4'b1000, 7'h00, 7'h00, 7'h00, 7'h00, 4'b0111};
    vecs[3] = '{16'h56EF, 4'h0,    7'h0E, 7'h06, 7'h02, 7'h12, 4'hF};
    vecs[4] = '{16'h9070, 4'b0101, 7'h40, 7'h78, 7'h40, 7'h10, 4'b1010};
    vecs[5] = '{16'h00A0, 4'h0,    7'h40, 7'h08, 7'h40, 7'h40, LIT_00A0};
    vecs[6] = '{16'h0000, 4'h0,    7'h40, 7'h40, 7'h40, 7'h40, LIT_0000};
    vecs[7] = '{16'h0F00, 4'h0,    7'h40, 7'h40, 7'h0E, 7'h40, LIT_0F00};
    v5555   = '{16'h5555, 4'h0,    7'h12, 7'h12, 7'h12, 7'h12, 4'hF};
    v3c3c   = '{16'h3C3C, 4'h0,    7'h46, 7'h30, 7'h46, 7'h30, 4'hF};
    vzero   = vecs[6];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_ready", 32'(load_ready), 32'h1);
    chk("rst_fs", 32'(frame_start), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("fs_first_after_reset", 32'(frame_start), 32'h1);
    chk("g0_fs_first_after_reset", 32'(fs2), 32'h1);

    check_dut2();

    for (int i = 0; i < NV; i++) begin
      blank_mask = vecs[i].mask;
      load_value(vecs[i].value);
      check_frame(vecs[i], $sformatf("vec%0d", i));
    end
    blank_mask = 4'h0;

    // Commit exactly at frame_start; a load offered while busy is held off
    load_value(16'h1234);
    wait_commit(100, ok);
    load_value(16'hABCD);
    load_valid = 1'b1;
    load_data  = 16'h5555;
    prev = seg;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (frame_start) begin ok = 1'b1; break; end
      chk("busy_ready_low", 32'(load_ready), 32'h0);
      prev = seg;
    end
    if (!ok) timeout("abcd_commit_wait");
    chk("old_msd_before_edge", 32'(prev), 32'h79);
    chk("abcd_digit0_at_frame_start", 32'(seg), 32'h21);
    chk("ready_back_at_commit", 32'(load_ready), 32'h1);
    tick();
    load_valid = 1'b0;
    chk("5555_accepted", 32'(load_ready), 32'h0);
    check_frame(v5555, "v5555");

    // Accept on the frame-edge cycle commits one frame later
    wait_fs(40, ok);
    repeat (15) tick();
    chk("ready_before_edge_accept", 32'(load_ready), 32'h1);
    load_valid = 1'b1;
    load_data  = 16'h3C3C;
    tick();
    load_valid = 1'b0;
    chk("edge_accept_fs", 32'(frame_start), 32'h1);
    chk("edge_accept_pending", 32'(load_ready), 32'h0);
    chk("edge_accept_old_digit0", 32'(seg), 32'h12);
    check_frame(v3c3c, "v3c3c");

    // Asynchronous reset mid-frame with a load pending
    load_value(16'hBEEF);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_seg", 32'(seg), 32'h7F);
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_ready", 32'(load_ready), 32'h1);
    chk("midrst_fs", 32'(frame_start), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_fs_first", 32'(frame_start), 32'h1);
    tick();
    check_frame(vzero, "post_rst_a");
    check_frame(vzero, "post_rst_b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
